// File: rtl/instr_encoder_loader.sv
// Encodes symbolic lw/sw/R-type/beq requests into RV32I words and writes them to
// consecutive instruction-memory word addresses through a stallable write port.
module instr_encoder_loader #(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [2:0]        in_alu,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [12:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_WRITE, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state_q;
    logic              in_ready_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              last_q;

    logic [31:0]       wdata_d;
    logic              legal_d;
    logic [2:0]        funct3;
    logic [6:0]        funct7;

    // Immediate bits are routed straight into their instruction fields; no arithmetic.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        wdata_d = '0;
        legal_d = 1'b1;
        funct3  = 3'b000;
        funct7  = 7'b0000000;
        case (in_alu)
            3'b000:  funct3 = 3'b000;
            3'b001:  funct7 = 7'b0100000;
            3'b010:  funct3 = 3'b111;
            3'b011:  funct3 = 3'b110;
            3'b101:  funct3 = 3'b010;
            default: funct3 = 3'b000;
        endcase
        case (in_kind)
            2'b00: wdata_d = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
            2'b01: wdata_d = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
            2'b10: begin
                wdata_d = {funct7, in_rs2, in_rs1, funct3, in_rd, 7'b0110011};
                legal_d = (in_alu inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b101});
            end
            default: begin
                wdata_d = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                           in_imm[4:1], in_imm[11], 7'b1100011};
                legal_d = ~in_imm[0];
            end
        endcase
    end

    // NOTE: all state and outputs are registered with non-blocking assignments so every
    // flop samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            mem_we_q   <= 1'b0;
            addr_q     <= BASE;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    busy_q     <= 1'b0;
                    in_ready_q <= 1'b0;
                    state_q    <= S_IDLE;
                    if (start) begin
                        state_q    <= S_ACCEPT;
                        addr_q     <= BASE;
                        err_q      <= 1'b0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                S_ACCEPT: begin
                    if (in_valid && in_ready_q) begin
                        if (legal_d) begin
                            wdata_q    <= wdata_d;
                            mem_we_q   <= 1'b1;
                            in_ready_q <= 1'b0;
                            last_q     <= in_last;
                            state_q    <= S_WRITE;
                        end else begin
                            err_q <= 1'b1;
                            if (in_last) begin
                                in_ready_q <= 1'b0;
                                busy_q     <= 1'b0;
                                done_q     <= 1'b1;
                                state_q    <= S_DONE;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        mem_we_q <= 1'b0;
                        if (last_q || addr_q == LAST_ADDR) begin
                            // Running off the top of memory ends the session with an error.
                            if (!last_q) err_q <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            addr_q     <= addr_q + ADDR_W'(1);
                            in_ready_q <= 1'b1;
                            state_q    <= S_ACCEPT;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: a 64-word instance for the main scenarios
// and a 4-word instance for address overflow.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        reset, start, start2, in_valid, in_last, mem_ack;
    logic [1:0]  in_kind;
    logic [2:0]  in_alu;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [12:0] in_imm;

    logic        in_ready, mem_we, busy, done, err;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        in_ready2, mem_we2, busy2, done2, err2;
    logic [1:0]  mem_addr2;
    logic [31:0] mem_wdata2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [5:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    logic [1:0]  wr2_addr[$];
    logic [31:0] wr2_data[$];
    int          done_cnt;

    instr_encoder_loader #(.ADDR_W(6), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_alu(in_alu), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .busy(busy), .done(done), .err(err)
    );

    instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .in_valid(in_valid), .in_ready(in_ready2),
        .in_kind(in_kind), .in_alu(in_alu), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we2), .mem_addr(mem_addr2),
        .mem_wdata(mem_wdata2), .mem_ack(mem_ack), .busy(busy2), .done(done2), .err(err2)
    );

    always #5 clk = ~clk;

    // Writes are logged half a cycle before the edge that commits them.
    always @(negedge clk) begin
        if (mem_we && mem_ack) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
        if (mem_we2 && mem_ack) begin
            wr2_addr.push_back(mem_addr2);
            wr2_data.push_back(mem_wdata2);
        end
        if (done) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr2_addr.delete();
        wr2_data.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) start2 = 1'b1; else start = 1'b1;
        tick();
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic send(input bit sel, input logic [1:0] kind, input logic [2:0] alu,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [12:0] imm, input logic last);
        int w = 0;
        in_kind = kind; in_alu = alu; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_imm = imm; in_last = last; in_valid = 1'b1;
        while (!(sel ? in_ready2 : in_ready) && w < 50) begin
            tick();
            w++;
        end
        n_checks++;
        if (w >= 50) begin
            n_fail++;
            $display("FAIL send_timeout in_ready got=0 exp=1");
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input bit sel);
        int w = 0;
        while (!(sel ? done2 : done) && w < 50) begin
            tick();
            w++;
        end
        n_checks++;
        if (w >= 50) begin
            n_fail++;
            $display("FAIL done_timeout done got=0 exp=1");
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 0; start2 = 0; in_valid = 0; in_last = 0; mem_ack = 0;
        in_kind = 0; in_alu = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_imm = 0;
        tick();
        tick();
        n_checks++;
        if ({in_ready, mem_we, busy, done, err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags got=%b exp=00000", {in_ready, mem_we, busy, done, err});
        end
        n_checks++;
        if (mem_addr !== 6'd0 || mem_wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_addr_data got=%0d/%h exp=0/00000000", mem_addr, mem_wdata);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_lw_stall();
        clear_log();
        mem_ack = 1'b0;
        pulse_start(0);
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL start_busy got=%b%b exp=11", busy, in_ready);
        end
        send(0, 2'b00, 3'b000, 5'd5, 5'd1, 5'd0, 13'd8, 1'b1);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 6'd0, 32'h0080A283}) begin
                n_fail++;
                $display("FAIL lw_stall%0d got=%b/%0d/%h exp=1/0/0080a283", i, mem_we, mem_addr, mem_wdata);
            end
            if (i < 3) tick();
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        n_checks++;
        if ({done, busy, mem_we} !== 3'b100) begin
            n_fail++;
            $display("FAIL lw_done got=%b exp=100", {done, busy, mem_we});
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL lw_done_pulse got=%b/%0d exp=0/1", done, done_cnt);
        end
        n_checks++;
        if (wr_addr.size() !== 1 || wr_addr[0] !== 6'd0 || wr_data[0] !== 32'h0080A283) begin
            n_fail++;
            $display("FAIL lw_write got=%0d writes first=%h exp=1 writes 0080a283", wr_addr.size(), wr_data[0]);
        end
    endtask

    task automatic test_session();
        logic [31:0] exp_d[3] = '{32'h00612223, 32'h402081B3, 32'hFE208EE3};
        clear_log();
        mem_ack = 1'b1;
        pulse_start(0);
        send(0, 2'b01, 3'b000, 5'd0, 5'd2, 5'd6, 13'd4, 1'b0);
        n_checks++;
        if (mem_we !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL session_latency got=%b%b exp=10", mem_we, in_ready);
        end
        send(0, 2'b10, 3'b001, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0);
        send(0, 2'b11, 3'b000, 5'd0, 5'd1, 5'd2, 13'h1FFC, 1'b1);
        wait_done(0);
        mem_ack = 1'b0;
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL session_err got=%b exp=0", err);
        end
        n_checks++;
        if (wr_addr.size() !== 3) begin
            n_fail++;
            $display("FAIL session_count got=%0d exp=3", wr_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (wr_addr[i] !== 6'(i) || wr_data[i] !== exp_d[i]) begin
                    n_fail++;
                    $display("FAIL session_write%0d got=%0d/%h exp=%0d/%h", i, wr_addr[i], wr_data[i], i, exp_d[i]);
                end
            end
        end
        tick();
    endtask

    task automatic test_illegal();
        clear_log();
        mem_ack = 1'b1;
        pulse_start(0);
        send(0, 2'b10, 3'b100, 5'd1, 5'd0, 5'd0, 13'd0, 1'b0);
        n_checks++;
        if ({err, mem_we, in_ready} !== 3'b101) begin
            n_fail++;
            $display("FAIL illegal_alu got=%b exp=101", {err, mem_we, in_ready});
        end
        send(0, 2'b11, 3'b000, 5'd0, 5'd1, 5'd2, 13'd3, 1'b0);
        n_checks++;
        if (mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_beq mem_we got=%b exp=0", mem_we);
        end
        send(0, 2'b10, 3'b000, 5'd1, 5'd0, 5'd0, 13'd0, 1'b1);
        wait_done(0);
        mem_ack = 1'b0;
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_sticky got=%b exp=1", err);
        end
        n_checks++;
        if (wr_addr.size() !== 1 || wr_addr[0] !== 6'd0 || wr_data[0] !== 32'h000000B3) begin
            n_fail++;
            $display("FAIL illegal_write got=%0d writes first=%h exp=1 writes 000000b3", wr_addr.size(), wr_data[0]);
        end
        tick();
    endtask

    task automatic test_overflow();
        logic [31:0] exp_d[4] = '{32'h00002083, 32'h00002103, 32'h00002183, 32'h00002203};
        bit seen_ready = 1'b0;
        clear_log();
        mem_ack = 1'b1;
        pulse_start(1);
        for (int i = 0; i < 4; i++) send(1, 2'b00, 3'b000, 5'(i + 1), 5'd0, 5'd0, 13'd0, 1'b0);
        wait_done(1);
        n_checks++;
        if (err2 !== 1'b1 || busy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_err got=%b%b exp=10", err2, busy2);
        end
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (in_ready2) seen_ready = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        mem_ack  = 1'b0;
        n_checks++;
        if (seen_ready !== 1'b0 || wr2_addr.size() !== 4) begin
            n_fail++;
            $display("FAIL overflow_fifth got=%b/%0d exp=0/4", seen_ready, wr2_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (wr2_addr[i] !== 2'(i) || wr2_data[i] !== exp_d[i]) begin
                    n_fail++;
                    $display("FAIL overflow_write%0d got=%0d/%h exp=%0d/%h", i, wr2_addr[i], wr2_data[i], i, exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midwrite();
        clear_log();
        mem_ack = 1'b1;
        pulse_start(0);
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL start_clears_err got=%b exp=0", err);
        end
        send(0, 2'b00, 3'b000, 5'd7, 5'd0, 5'd0, 13'd0, 1'b0);
        send(0, 2'b00, 3'b000, 5'd8, 5'd0, 5'd0, 13'd0, 1'b0);
        mem_ack = 1'b0;
        n_checks++;
        if (mem_we !== 1'b1 || mem_addr !== 6'd1) begin
            n_fail++;
            $display("FAIL midwrite_pre got=%b/%0d exp=1/1", mem_we, mem_addr);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({mem_we, busy, in_ready} !== 3'b000 || mem_addr !== 6'd0) begin
            n_fail++;
            $display("FAIL midwrite_reset got=%b/%0d exp=000/0", {mem_we, busy, in_ready}, mem_addr);
        end
        tick();
        reset = 1'b0;
        tick();
        mem_ack = 1'b1;
        pulse_start(0);
        send(0, 2'b01, 3'b000, 5'd0, 5'd2, 5'd6, 13'd4, 1'b1);
        wait_done(0);
        mem_ack = 1'b0;
        n_checks++;
        if (wr_addr.size() !== 2 || wr_data[0] !== 32'h00002383 || wr_addr[1] !== 6'd0
            || wr_data[1] !== 32'h00612223) begin
            n_fail++;
            $display("FAIL midwrite_restart got=%0d writes last=%0d/%h exp=2 writes 0/00612223",
                     wr_addr.size(), wr_addr[wr_addr.size()-1], wr_data[wr_data.size()-1]);
        end
        tick();
    endtask

    task automatic test_start_in_accept();
        clear_log();
        mem_ack = 1'b1;
        pulse_start(0);
        send(0, 2'b00, 3'b000, 5'd1, 5'd0, 5'd0, 13'd0, 1'b0);
        tick();
        pulse_start(0);
        n_checks++;
        if ({busy, in_ready} !== 2'b11 || mem_addr !== 6'd1) begin
            n_fail++;
            $display("FAIL accept_start got=%b/%0d exp=11/1", {busy, in_ready}, mem_addr);
        end
        send(0, 2'b10, 3'b000, 5'd1, 5'd0, 5'd0, 13'd0, 1'b1);
        wait_done(0);
        mem_ack = 1'b0;
        n_checks++;
        if (wr_addr.size() !== 2 || wr_addr[1] !== 6'd1 || wr_data[1] !== 32'h000000B3) begin
            n_fail++;
            $display("FAIL accept_start_write got=%0d writes second=%0d/%h exp=2 writes 1/000000b3",
                     wr_addr.size(), wr_addr[1], wr_data[1]);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_lw_stall();
        test_session();
        test_illegal();
        test_overflow();
        test_reset_midwrite();
        test_start_in_accept();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the control-path decoder. Accepts symbolic instruction requests (lw, sw, R-type, beq) over a valid/ready handshake.
- Encodes each request into a 32-bit RV32I word and writes it to consecutive instruction-memory word addresses through a stallable write port.
- Used by the bench/boot path to load programs into the single-cycle core's instruction memory without a precompiled hex file.

Parameters:
ADDR_W, 6, instruction-memory word-address width (2^ADDR_W words)
BASE_ADDR, 0, first word address written after start

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  begin a load session; address counter := BASE_ADDR, err cleared
in_valid  in  1  request valid
in_ready  out  1  block can accept a request this cycle
in_kind  in  2  00 lw, 01 sw, 10 R-type, 11 beq
in_alu  in  3  R-type op: 000 add, 001 sub, 010 and, 011 or, 101 slt; others illegal
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_imm  in  13  signed immediate; lw/sw use [11:0], beq uses [12:0]
in_last  in  1  request is the final one of the session
mem_we  out  1  write request to instruction memory
mem_addr  out  ADDR_W  word address
mem_wdata  out  32  encoded instruction
mem_ack  in  1  memory accepted the write this cycle
busy  out  1  session in progress
done  out  1  one-cycle pulse at session end
err  out  1  sticky error flag

Behaviour:
- Reset (async, immediate, including mid-write): state IDLE; in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, done=0, err=0.
- States:
  - IDLE: start -> ACCEPT, addr=BASE_ADDR, err=0.
  - ACCEPT: in_ready=1, busy=1. On in_valid&in_ready, register the encoded word. Legal request -> WRITE. Illegal request -> set err, drop the request (no write, address unchanged); then in_last -> DONE, else stay in ACCEPT.
  - WRITE: mem_we=1; mem_addr and mem_wdata held stable until mem_ack. On ack, mem_we drops the next cycle.
    - If the item was in_last: -> DONE.
    - Else if addr == 2^ADDR_W-1: set err (overflow) and -> DONE.
    - Else addr+1, -> ACCEPT.
  - DONE: done=1 for exactly one cycle, busy=0, -> IDLE.
- start is ignored in ACCEPT/WRITE. It is honoured in IDLE, and in DONE as if in IDLE.
- Latency: handshake in cycle N -> mem_we=1 in N+1. Minimum 2 cycles per instruction: in_ready is 0 throughout WRITE, so no back-to-back accept.
- Illegal conditions, each sets err: in_alu not in the legal set for R-type; beq with in_imm[0]=1. in_alu is ignored for non-R kinds.
- err stays set until reset or the next accepted start.
- Encoding, MSB to LSB:
  - lw: imm[11:0] rs1 010 rd 0000011
  - sw: imm[11:5] rs2 rs1 010 imm[4:0] 0100011
  - R-type: funct7 rs2 rs1 funct3 rd 0110011
    - funct3: add/sub 000, slt 010, or 110, and 111
    - funct7: 0100000 for sub, 0000000 otherwise
  - beq: imm[12] imm[10:5] rs2 rs1 000 imm[4:1] imm[11] 1100011
- No arithmetic on immediates; bits are routed directly. in_imm[12] is ignored for lw/sw.

Test Plan:
- Reset, then start, then lw rd=5 rs1=1 imm=8 with in_last=1, mem_ack after 3 stall cycles -> single write of 0x0080A283 at addr 0; mem_we/addr/wdata held stable across the stall; done pulses once; busy falls.
- Session of sw rs2=6 rs1=2 imm=4, sub rd=3 rs1=1 rs2=2, beq rs1=1 rs2=2 imm=-4 (last), mem_ack tied 1 -> writes 0x00612223@0, 0x402081B3@1, 0xFE208EE3@2; err=0.
- R-type with in_alu=100, followed by add rd=1 rs1=0 rs2=0 (last) -> err=1, only one write: 0x000000B3 at addr 0.
- ADDR_W=2, five non-last requests -> writes at addrs 0..3, then err=1 and done after the 4th ack; 5th never accepted.
- reset asserted while mem_we=1 -> same-cycle mem_we=0, busy=0; a subsequent start restarts at BASE_ADDR.
- start pulsed during ACCEPT after one write -> address not reset; next write lands at addr 1.
